// File: rtl/vga_fb_pkg.sv
// Geometry constants and RAM-command state shared by the VGA frame-buffer arbiter.
package vga_fb_pkg;

   localparam int SCREEN_X = 640;
   localparam int SCREEN_Y = 480;
   localparam int SCALE    = 4;
   localparam int LOG      = $clog2(SCALE);
   localparam int FB_W     = SCREEN_X / SCALE;
   localparam int FB_H     = SCREEN_Y / SCALE;
   localparam int FB_DEPTH = FB_W * FB_H;
   localparam int ADDR_W   = 15;
   localparam int RGB_W    = 12;
   localparam int POS_W    = 10;

   // Command currently presented on the registered RAM port
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRD  = 2'd1,
      WR   = 2'd2
   } fbState_t;

endpackage

// File: rtl/vga_fb_addr_gen.sv
// Row-major frame-buffer address: row*COLS + col, COLS being a constant.
module vga_fb_addr_gen
   import vga_fb_pkg::*;
#(
   parameter int COLS  = FB_W,
   parameter int ROW_W = 8,
   parameter int COL_W = 8,
   parameter int AW    = ADDR_W
) (
   input  logic [ROW_W-1:0] row,
   input  logic [COL_W-1:0] col,
   output logic [AW-1:0]    addr
);

   localparam logic [AW-1:0] COLS_C = AW'(COLS);

   logic [AW-1:0] rowExt;
   logic [AW-1:0] colExt;

   assign rowExt = AW'(row);
   assign colExt = AW'(col);
   assign addr   = rowExt * COLS_C + colExt;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: upscaled VGA fetch has absolute priority,
// one valid/ready pixel writer fills the remaining RAM cycles.
module vga_fb_arbiter
   import vga_fb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [POS_W-1:0]  posX,
   input  logic [POS_W-1:0]  posY,
   output logic [RGB_W-1:0]  pixel_out,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [RGB_W-1:0]  wr_data,
   output logic              wr_ready,
   output logic              wr_err,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [RGB_W-1:0]  ram_wdata,
   input  logic [RGB_W-1:0]  ram_rdata,
   output logic              vblank,
   output logic              frame_start
);

   localparam int COL_W = POS_W - LOG;
   localparam int ROW_W = POS_W - LOG;

   logic [COL_W-1:0]  col_p0;
   logic [COL_W:0]    colNext_p0;
   logic [LOG-1:0]    sub_p0;
   logic [ROW_W-1:0]  row_p0;
   logic [POS_W:0]    nextY_p0;
   logic [ROW_W-1:0]  preRow_p0;
   logic              colFetch_p0;
   logic              preload_p0;
   logic              dispSlot_p0;
   logic              xfer_p0;
   logic              inRange_p0;
   logic [ROW_W-1:0]  genRow_p0;
   logic [COL_W-1:0]  genCol_p0;
   logic [ADDR_W-1:0] target_p0;
   fbState_t          state;
   logic              vld_p2;

   // ---- stage p0: slot decode from the display position ----
   assign col_p0     = posX[POS_W-1:LOG];
   assign sub_p0     = posX[LOG-1:0];
   assign row_p0     = posY[POS_W-1:LOG];
   assign colNext_p0 = {1'b0, col_p0} + (COL_W+1)'(1);
   assign nextY_p0   = {1'b0, posY} + (POS_W+1)'(1);

   // Fetch the next buffer column three cycles before it is displayed; the
   // last column has no successor on the line, so it is never fetched here.
   assign colFetch_p0 = (sub_p0 == LOG'(SCALE - 3)) &&
                        (colNext_p0 < (COL_W+1)'(FB_W)) &&
                        (posY < POS_W'(SCREEN_Y));

   // Column 0 of the following line is fetched during horizontal blanking;
   // the last visible line wraps to buffer row 0 for the next frame.
   assign preload_p0 = (posX == POS_W'(SCREEN_X));
   assign preRow_p0  = (nextY_p0 >= (POS_W+1)'(SCREEN_Y)) ? '0 : nextY_p0[POS_W-1:LOG];

   assign genRow_p0 = preload_p0 ? preRow_p0 : row_p0;
   assign genCol_p0 = preload_p0 ? '0 : colNext_p0[COL_W-1:0];

   vga_fb_addr_gen #(
      .COLS  (FB_W),
      .ROW_W (ROW_W),
      .COL_W (COL_W),
      .AW    (ADDR_W)
   ) addrGen (
      .row  (genRow_p0),
      .col  (genCol_p0),
      .addr (target_p0)
   );

   assign dispSlot_p0 = colFetch_p0 | preload_p0;
   assign wr_ready    = !dispSlot_p0;
   assign xfer_p0     = wr_valid & !dispSlot_p0;
   assign inRange_p0  = (wr_addr < ADDR_W'(FB_DEPTH));

   // ---- stage p1: registered RAM command (display read beats writer) ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ram_addr  <= '0;
         ram_we    <= 1'b0;
         ram_wdata <= '0;
         wr_err    <= 1'b0;
      end else begin
         ram_we <= 1'b0;
         wr_err <= 1'b0;
         if (dispSlot_p0) begin
            state    <= DRD;
            ram_addr <= target_p0;
         end else if (xfer_p0) begin
            state <= WR;
            if (inRange_p0) begin
               ram_addr  <= wr_addr;
               ram_wdata <= wr_data;
               ram_we    <= 1'b1;
            end else begin
               wr_err <= 1'b1;
            end
         end else begin
            state <= IDLE;
         end
      end
   end

   // ---- stage p2: RAM data returns; capture it into the held output pixel ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2    <= 1'b0;
         pixel_out <= '0;
      end else begin
         vld_p2 <= (state == DRD);
         if (vld_p2) begin
            pixel_out <= ram_rdata;
         end
      end
   end

   // Registered frame status derived from the incoming display position
   always_ff @(posedge clk) begin
      if (rst) begin
         vblank      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         vblank      <= (posY >= POS_W'(SCREEN_Y));
         frame_start <= (posX == '0) && (posY == '0);
      end
   end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomised scoreboard bench for vga_fb_arbiter with a behavioural RAM.
module tb_vga_fb_arbiter;
   import vga_fb_pkg::*;

   localparam int LINE_X = 800;

   typedef struct {
      int               due;
      logic             err;
      logic [ADDR_W-1:0] addr;
      logic [RGB_W-1:0]  data;
   } wrExp_t;

   typedef struct {
      int               due;
      logic [ADDR_W-1:0] addr;
   } rdExp_t;

   typedef struct {
      int              due;
      logic [RGB_W-1:0] val;
   } pixExp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [POS_W-1:0]  posX;
   logic [POS_W-1:0]  posY;
   logic [RGB_W-1:0]  pixel_out;
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [RGB_W-1:0]  wr_data;
   logic              wr_ready;
   logic              wr_err;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [RGB_W-1:0]  ram_wdata;
   logic [RGB_W-1:0]  ram_rdata;
   logic              vblank;
   logic              frame_start;

   vga_fb_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .posX        (posX),
      .posY        (posY),
      .pixel_out   (pixel_out),
      .wr_valid    (wr_valid),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .wr_err      (wr_err),
      .ram_addr    (ram_addr),
      .ram_we      (ram_we),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata),
      .vblank      (vblank),
      .frame_start (frame_start)
   );

   always #20 clk = ~clk;

   logic [RGB_W-1:0] ram  [int];
   logic [RGB_W-1:0] gold [int];

   wrExp_t  wrQ[$];
   rdExp_t  rdQ[$];
   pixExp_t pixQ[$];

   int   checks;
   int   failures;
   int   cyc;
   int   rstDue;
   logic monOn;
   logic expReady;
   logic expVb;
   logic expFs;

   logic              pending;
   logic [ADDR_W-1:0] pAddr;
   logic [RGB_W-1:0]  pData;
   int                wrRate;
   int                oorPct;
   int                streamLeft;
   int                cntY;
   int                actCnt;
   int                blkCnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [RGB_W-1:0] goldRead(input int a);
      return gold.exists(a) ? gold[a] : RGB_W'(a);
   endfunction

   function automatic logic [RGB_W-1:0] ramRead(input int a);
      return ram.exists(a) ? ram[a] : RGB_W'(a);
   endfunction

   // Which display position claims the RAM, and for which buffer word
   function automatic void slotOf(input int x, input int y, output bit hit, output int tgt);
      int col;
      int sub;
      int row;
      col = x / SCALE;
      sub = x % SCALE;
      row = y / SCALE;
      hit = 1'b0;
      tgt = 0;
      if (x == SCREEN_X) begin
         hit = 1'b1;
         tgt = ((y + 1 >= SCREEN_Y) ? 0 : (y + 1) / SCALE) * FB_W;
      end else if (sub == SCALE - 3 && col + 1 < FB_W && y < SCREEN_Y) begin
         hit = 1'b1;
         tgt = row * FB_W + col + 1;
      end
   endfunction

   // Single-port synchronous RAM, read-before-write, unwritten words read addr[11:0]
   task automatic ramLoop();
      int a;
      forever begin
         @(posedge clk);
         a = int'(ram_addr);
         ram_rdata <= ramRead(a);
         if (ram_we) ram[a] = ram_wdata;
      end
   endtask

   task automatic monitorLoop();
      wrExp_t           we;
      rdExp_t           re;
      pixExp_t          pe;
      logic [RGB_W-1:0] curPix;
      curPix = '0;
      forever begin
         @(negedge clk);
         if (!monOn) continue;
         if (cyc == rstDue) begin
            chk("rst_ram_addr", 32'(ram_addr), 32'd0);
            chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
            chk("rst_pixel_out", 32'(pixel_out), 32'd0);
         end
         chk("wr_ready", 32'(wr_ready), 32'(expReady));
         chk("vblank", 32'(vblank), 32'(expVb));
         chk("frame_start", 32'(frame_start), 32'(expFs));
         if (wrQ.size() > 0 && wrQ[0].due == cyc) begin
            we = wrQ.pop_front();
            if (we.err) begin
               chk("oor_ram_we", 32'(ram_we), 32'd0);
               chk("oor_wr_err", 32'(wr_err), 32'd1);
            end else begin
               chk("wr_ram_we", 32'(ram_we), 32'd1);
               chk("wr_ram_addr", 32'(ram_addr), 32'(we.addr));
               chk("wr_ram_wdata", 32'(ram_wdata), 32'(we.data));
               chk("wr_err_quiet", 32'(wr_err), 32'd0);
            end
         end else begin
            chk("idle_ram_we", 32'(ram_we), 32'd0);
            chk("idle_wr_err", 32'(wr_err), 32'd0);
         end
         if (rdQ.size() > 0 && rdQ[0].due == cyc) begin
            re = rdQ.pop_front();
            chk("rd_ram_addr", 32'(ram_addr), 32'(re.addr));
         end
         if (pixQ.size() > 0 && pixQ[0].due == cyc) begin
            pe = pixQ.pop_front();
            curPix = pe.val;
         end
         chk("pixel_out", 32'(pixel_out), 32'(curPix));
      end
   endtask

   // One pixel-clock cycle: resolve the handshake of the cycle just ended,
   // then drive the next position and record what the RAM port must do.
   task automatic step(input int x, input int y, input logic r);
      bit      hit;
      int      tgt;
      rdExp_t  re;
      pixExp_t pe;
      wrExp_t  we;
      @(posedge clk);
      if (monOn && !rst && wr_valid && wr_ready) begin
         we.due  = cyc + 1;
         we.addr = wr_addr;
         we.data = wr_data;
         we.err  = (int'(wr_addr) >= FB_DEPTH);
         if (!we.err) gold[int'(wr_addr)] = wr_data;
         wrQ.push_back(we);
         pending = 1'b0;
         if (int'(posY) == cntY) begin
            if (int'(posX) < SCREEN_X) actCnt++;
            else blkCnt++;
         end
      end
      expVb = rst ? 1'b0 : (int'(posY) >= SCREEN_Y);
      expFs = rst ? 1'b0 : (posX == '0 && posY == '0);
      #1;
      cyc++;
      rst  = r;
      posX = POS_W'(x);
      posY = POS_W'(y);
      if (!pending && streamLeft > 0 && $urandom_range(0, 99) < wrRate) begin
         pending = 1'b1;
         streamLeft--;
         if ($urandom_range(0, 99) < oorPct)
            pAddr = ADDR_W'($urandom_range(FB_DEPTH, (1 << ADDR_W) - 1));
         else
            pAddr = ADDR_W'($urandom_range(0, FB_DEPTH - 1));
         pData = RGB_W'($urandom);
      end
      wr_valid = pending;
      wr_addr  = pAddr;
      wr_data  = pData;
      slotOf(x, y, hit, tgt);
      expReady = !hit;
      if (r) begin
         while (wrQ.size() > 0 && wrQ[$].due > cyc) void'(wrQ.pop_back());
         while (rdQ.size() > 0 && rdQ[$].due > cyc) void'(rdQ.pop_back());
         while (pixQ.size() > 0 && pixQ[$].due > cyc) void'(pixQ.pop_back());
         rstDue = cyc + 1;
         pe.due = cyc + 1;
         pe.val = '0;
         pixQ.push_back(pe);
      end else if (hit) begin
         re.due  = cyc + 1;
         re.addr = ADDR_W'(tgt);
         rdQ.push_back(re);
         pe.due = cyc + 3;
         pe.val = goldRead(tgt);
         pixQ.push_back(pe);
      end
      monOn = 1'b1;
   endtask

   task automatic runLine(input int y, input int xMax, input int rstAt);
      for (int x = 0; x <= xMax; x++) step(x, y, (x == rstAt));
   endtask

   initial begin
      int mism;
      checks     = 0;
      failures   = 0;
      cyc        = 0;
      rstDue     = -1;
      monOn      = 1'b0;
      expReady   = 1'b1;
      expVb      = 1'b0;
      expFs      = 1'b0;
      rst        = 1'b1;
      posX       = '0;
      posY       = '0;
      wr_valid   = 1'b0;
      wr_addr    = '0;
      wr_data    = '0;
      pending    = 1'b0;
      pAddr      = '0;
      pData      = '0;
      wrRate     = 0;
      oorPct     = 0;
      streamLeft = 0;
      cntY       = -1;
      actCnt     = 0;
      blkCnt     = 0;
      fork
         ramLoop();
         monitorLoop();
      join_none

      // Reset held for two cycles with a write already waiting
      pending = 1'b1;
      pAddr   = ADDR_W'(5);
      pData   = 12'h123;
      step(0, 524, 1'b1);
      step(1, 524, 1'b1);
      for (int x = 2; x < LINE_X; x++) step(x, 524, 1'b0);

      // Last visible line preloads buffer row 0, then frame line 0 with a write at posX=1
      runLine(479, LINE_X - 1, -1);
      step(0, 0, 1'b0);
      pending = 1'b1;
      pAddr   = ADDR_W'(100);
      pData   = 12'hABC;
      for (int x = 1; x < LINE_X; x++) step(x, 0, 1'b0);

      // Preload of row 1 and column fetches of buffer row 2
      runLine(3, LINE_X - 1, -1);
      runLine(8, LINE_X - 1, -1);

      // Out-of-range write in vertical blanking, then overshooting counters
      step(0, 500, 1'b0);
      for (int x = 1; x < 10; x++) step(x, 500, 1'b0);
      pending = 1'b1;
      pAddr   = ADDR_W'(FB_DEPTH);
      pData   = 12'h555;
      for (int x = 10; x < LINE_X; x++) step(x, 500, 1'b0);
      runLine(1023, 1023, -1);

      // Saturating 1000-write stream across an active line
      wrRate     = 100;
      oorPct     = 0;
      streamLeft = 1000;
      cntY       = 100;
      actCnt     = 0;
      blkCnt     = 0;
      runLine(100, LINE_X - 1, -1);
      runLine(101, LINE_X - 1, -1);
      chk("stream_active_xfers", 32'(actCnt), 32'(SCREEN_X - (FB_W - 1)));
      chk("stream_blank_xfers", 32'(blkCnt), 32'(LINE_X - SCREEN_X - 1));
      chk("stream_issued", 32'(streamLeft), 32'd0);
      cntY = -1;

      // Random lines, random writer load, one mid-line reset
      oorPct     = 5;
      streamLeft = 1 << 30;
      for (int i = 0; i < 16; i++) begin
         wrRate = $urandom_range(0, 100);
         runLine($urandom_range(0, 524), ($urandom_range(0, 3) == 0) ? 1023 : LINE_X - 1,
                 (i == 8) ? 300 : -1);
      end

      // Drain the writer and the pipelines, then compare the whole buffer
      wrRate     = 0;
      streamLeft = 0;
      runLine(500, LINE_X - 1, -1);
      for (int x = 0; x < 4; x++) step(x, 500, 1'b0);
      chk("writer_drained", 32'(pending), 32'd0);
      chk("queues_drained", 32'(wrQ.size() + rdQ.size() + pixQ.size()), 32'd0);
      mism = 0;
      for (int a = 0; a < FB_DEPTH; a++) begin
         if (ramRead(a) !== goldRead(a)) mism++;
      end
      chk("ram_contents_mismatches", 32'(mism), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
